// File: rtl/spi_slave_duplex.sv
// rtl/spi_slave_duplex.sv - parametrised full-duplex SPI slave with TX holding register
// Optional RX FIFO: define SPI_SLAVE_RX_FIFO_EN (default build: single-word RX, pulsed rx_valid).
module spi_slave_duplex #(
  parameter int                  BITS_LEN      = 8,
  parameter bit                  CPOL          = 1'b0,
  parameter bit                  CPHA          = 1'b0,
  parameter bit                  LSB_FIRST     = 1'b0,
  parameter logic [BITS_LEN-1:0] TX_IDLE       = '1,
  parameter int                  RX_FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                spi_clk,
  input  logic                spi_mosi,
  input  logic                spi_ss,
  output logic                spi_miso,
  output logic                spi_miso_oe,
  input  logic [BITS_LEN-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                tx_underrun,
  output logic [BITS_LEN-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                rx_overflow,
  output logic                frame_err,
  output logic                busy
);
  localparam int CW = $clog2(BITS_LEN + 1);

  logic [1:0]          sclk_sync, mosi_sync, ss_sync;
  logic                sclk_hist, ss_hist;
  logic                active;
  logic [CW-1:0]       bit_cnt;
  logic [BITS_LEN-1:0] rx_shift, tx_shift, hold;
  logic                hold_full, idle_loaded;

  // Two-flop synchronisers plus one history flop for edge detection.
  // SS resets to the "selected" level so a chip select that is already low
  // after reset never looks like a fresh falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= {2{CPOL}};
      sclk_hist <= CPOL;
      mosi_sync <= '0;
      ss_sync   <= '0;
      ss_hist   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_clk};
      sclk_hist <= sclk_sync[1];
      mosi_sync <= {mosi_sync[0], spi_mosi};
      ss_sync   <= {ss_sync[0], spi_ss};
      ss_hist   <= ss_sync[1];
    end
  end

  wire sclk_rise  = sclk_sync[1] & ~sclk_hist;
  wire sclk_fall  = ~sclk_sync[1] & sclk_hist;
  wire lead_edge  = CPOL ? sclk_fall : sclk_rise;
  wire trail_edge = CPOL ? sclk_rise : sclk_fall;
  wire ss_fall    = ~ss_sync[1] & ss_hist;
  wire ss_end     = active & ss_sync[1];
  wire selected   = active & ~ss_sync[1];
  wire sample_evt = selected & (CPHA ? trail_edge : lead_edge);
  // Shifting only mid-word skips the first CPHA=1 leading edge and the
  // CPHA=0 trailing edge that follows a word completion (new word already loaded).
  wire shift_evt  = selected & (CPHA ? lead_edge : trail_edge) & (bit_cnt != '0);
  wire mosi_bit   = mosi_sync[1];
  wire last_bit   = (bit_cnt == CW'(BITS_LEN - 1));
  wire word_end   = sample_evt & last_bit;
  wire tx_load    = ss_fall | word_end;

  wire [BITS_LEN-1:0] rx_next = LSB_FIRST ? {mosi_bit, rx_shift[BITS_LEN-1:1]}
                                          : {rx_shift[BITS_LEN-2:0], mosi_bit};

  assign tx_ready    = ~hold_full;
  assign busy        = active;
  assign spi_miso_oe = active;
  assign spi_miso    = active ? (LSB_FIRST ? tx_shift[0] : tx_shift[BITS_LEN-1]) : 1'bz;

  // Frame tracking, bit counter, RX/TX shifting and the TX holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      active      <= 1'b0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= TX_IDLE;
      hold        <= '0;
      hold_full   <= 1'b0;
      idle_loaded <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;

      if (ss_fall) active <= 1'b1;
      else if (ss_end) active <= 1'b0;

      if (ss_end) begin
        if (bit_cnt != '0) frame_err <= 1'b1;
        bit_cnt     <= '0;
        rx_shift    <= '0;
        tx_shift    <= TX_IDLE;
        idle_loaded <= 1'b0;
      end else if (sample_evt) begin
        rx_shift <= rx_next;
        // Underrun is reported when the idle word actually starts going out.
        if (bit_cnt == '0) begin
          tx_underrun <= idle_loaded;
          idle_loaded <= 1'b0;
        end
        if (last_bit) bit_cnt <= '0;
        else          bit_cnt <= bit_cnt + CW'(1);
      end else if (shift_evt) begin
        tx_shift <= LSB_FIRST ? (tx_shift >> 1) : (tx_shift << 1);
      end

      if (tx_load && !ss_end) begin
        if (hold_full) begin
          tx_shift    <= hold;
          hold_full   <= 1'b0;
          idle_loaded <= 1'b0;
        end else if (tx_valid) begin
          tx_shift    <= tx_data;
          idle_loaded <= 1'b0;
        end else begin
          tx_shift    <= TX_IDLE;
          idle_loaded <= 1'b1;
        end
      end else if (tx_valid && tx_ready) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int AW = $clog2(RX_FIFO_DEPTH);

  logic [BITS_LEN-1:0] fifo_mem [RX_FIFO_DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr;

  wire fifo_empty = (wr_ptr == rd_ptr);
  wire fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  wire fifo_pop   = rx_valid & rx_ready;

  assign rx_valid = ~fifo_empty;
  assign rx_data  = fifo_mem[rd_ptr[AW-1:0]];

  // RX FIFO: push completed words, drop on full unless a pop frees a slot this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rx_overflow <= 1'b0;
      for (int i = 0; i < RX_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      rx_overflow <= 1'b0;
      if (word_end) begin
        if (!fifo_full || fifo_pop) begin
          fifo_mem[wr_ptr[AW-1:0]] <= rx_next;
          wr_ptr <= wr_ptr + 1'b1;
        end else begin
          rx_overflow <= 1'b1;
        end
      end
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
`else
  logic unused_rx_ready;
  assign unused_rx_ready = rx_ready;
  assign rx_overflow     = 1'b0;

  // Single-word RX output: rx_data holds, rx_valid pulses for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= word_end;
      if (word_end) rx_data <= rx_next;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_duplex.sv
// tb/tb_spi_slave_duplex.sv - table-driven self-checking bench for spi_slave_duplex
`timescale 1ns/1ps
module tb_spi_slave_duplex;
  localparam int NI = 5;
  localparam int HC = 8;   // clk cycles per SCLK half period

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mosi = 1'b0;
  logic rx_rdy = 1'b1;
  logic sclk [NI];
  logic ss [NI];
  logic txv [NI];
  logic oe [NI], txr [NI], und [NI], rxv [NI], ovf [NI], ferr [NI], busy [NI];
  logic [7:0]  txd8 [4];
  logic [7:0]  rxd8 [4];
  logic [15:0] txd16, rxd16;
  wire miso0, miso1, miso2, miso3, miso4;

  always #5 clk = ~clk;

  // k0: mode0 MSB 8b, k1..k3: modes 1..3 LSB 8b, k4: mode0 MSB 16b
  spi_slave_duplex #(.BITS_LEN(8), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .spi_clk(sclk[0]), .spi_mosi(mosi), .spi_ss(ss[0]), .spi_miso(miso0),
    .spi_miso_oe(oe[0]), .tx_data(txd8[0]), .tx_valid(txv[0]), .tx_ready(txr[0]), .tx_underrun(und[0]),
    .rx_data(rxd8[0]), .rx_valid(rxv[0]), .rx_ready(rx_rdy), .rx_overflow(ovf[0]), .frame_err(ferr[0]), .busy(busy[0]));
  spi_slave_duplex #(.BITS_LEN(8), .CPOL(1'b0), .CPHA(1'b1), .LSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .spi_clk(sclk[1]), .spi_mosi(mosi), .spi_ss(ss[1]), .spi_miso(miso1),
    .spi_miso_oe(oe[1]), .tx_data(txd8[1]), .tx_valid(txv[1]), .tx_ready(txr[1]), .tx_underrun(und[1]),
    .rx_data(rxd8[1]), .rx_valid(rxv[1]), .rx_ready(rx_rdy), .rx_overflow(ovf[1]), .frame_err(ferr[1]), .busy(busy[1]));
  spi_slave_duplex #(.BITS_LEN(8), .CPOL(1'b1), .CPHA(1'b0), .LSB_FIRST(1'b1)) u2 (
    .clk(clk), .rst(rst), .spi_clk(sclk[2]), .spi_mosi(mosi), .spi_ss(ss[2]), .spi_miso(miso2),
    .spi_miso_oe(oe[2]), .tx_data(txd8[2]), .tx_valid(txv[2]), .tx_ready(txr[2]), .tx_underrun(und[2]),
    .rx_data(rxd8[2]), .rx_valid(rxv[2]), .rx_ready(rx_rdy), .rx_overflow(ovf[2]), .frame_err(ferr[2]), .busy(busy[2]));
  spi_slave_duplex #(.BITS_LEN(8), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b1)) u3 (
    .clk(clk), .rst(rst), .spi_clk(sclk[3]), .spi_mosi(mosi), .spi_ss(ss[3]), .spi_miso(miso3),
    .spi_miso_oe(oe[3]), .tx_data(txd8[3]), .tx_valid(txv[3]), .tx_ready(txr[3]), .tx_underrun(und[3]),
    .rx_data(rxd8[3]), .rx_valid(rxv[3]), .rx_ready(rx_rdy), .rx_overflow(ovf[3]), .frame_err(ferr[3]), .busy(busy[3]));
  spi_slave_duplex #(.BITS_LEN(16), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0)) u4 (
    .clk(clk), .rst(rst), .spi_clk(sclk[4]), .spi_mosi(mosi), .spi_ss(ss[4]), .spi_miso(miso4),
    .spi_miso_oe(oe[4]), .tx_data(txd16), .tx_valid(txv[4]), .tx_ready(txr[4]), .tx_underrun(und[4]),
    .rx_data(rxd16), .rx_valid(rxv[4]), .rx_ready(rx_rdy), .rx_overflow(ovf[4]), .frame_err(ferr[4]), .busy(busy[4]));

  function automatic bit cpol_of(input int k); return (k == 2) || (k == 3); endfunction
  function automatic bit cpha_of(input int k); return (k == 1) || (k == 3); endfunction
  function automatic bit lsb_of(input int k);  return (k >= 1) && (k <= 3); endfunction
  function automatic int len_of(input int k);  return (k == 4) ? 16 : 8; endfunction

  function automatic logic miso_of(input int k);
    case (k)
      0: return miso0;
      1: return miso1;
      2: return miso2;
      3: return miso3;
      default: return miso4;
    endcase
  endfunction

  function automatic logic [15:0] rx_of(input int k);
    return (k == 4) ? rxd16 : {8'h00, rxd8[k]};
  endfunction

  // Event counters sampled on the falling clk edge
  int rxv_cnt [NI];
  int und_cnt [NI];
  int ferr_cnt [NI];
  int ovf_cnt [NI];
  logic [15:0] last_rx [NI];

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rxv[k]) begin
        rxv_cnt[k] <= rxv_cnt[k] + 1;
        last_rx[k] <= rx_of(k);
      end
      if (und[k])  und_cnt[k]  <= und_cnt[k] + 1;
      if (ferr[k]) ferr_cnt[k] <= ferr_cnt[k] + 1;
      if (ovf[k])  ovf_cnt[k]  <= ovf_cnt[k] + 1;
    end
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input int k, input logic [15:0] d);
    check("tx_ready_before_push", {31'd0, txr[k]}, 32'd1);
    if (k == 4) txd16 = d;
    else txd8[k] = d[7:0];
    txv[k] = 1'b1;
    tick(1);
    txv[k] = 1'b0;
    check("tx_ready_after_push", {31'd0, txr[k]}, 32'd0);
  endtask

  // Master side: clock nb bits of mw out on MOSI, collect MISO into sw
  task automatic xfer_bits(input int k, input int nb, input logic [15:0] mw, output logic [15:0] sw);
    int n;
    int idx;
    bit cp;
    n = len_of(k);
    cp = cpol_of(k);
    sw = '0;
    for (int b = 0; b < nb; b++) begin
      idx = lsb_of(k) ? b : n - 1 - b;
      if (!cpha_of(k)) begin
        mosi = mw[idx];
        tick(HC);
        sclk[k] = ~cp;
        sw[idx] = miso_of(k);
        tick(HC);
        sclk[k] = cp;
      end else begin
        sclk[k] = ~cp;
        mosi = mw[idx];
        tick(HC);
        sclk[k] = cp;
        sw[idx] = miso_of(k);
        tick(HC);
      end
    end
  endtask

  task automatic ss_low(input int k);
    ss[k] = 1'b0;
    tick(HC);
  endtask

  task automatic ss_high(input int k);
    tick(HC);
    ss[k] = 1'b1;
    tick(2 * HC);
  endtask

  typedef struct {
    int          k;
    logic [15:0] tx;
    logic [15:0] mw;
    logic [15:0] exp_rx;
    logic [15:0] exp_miso;
  } vec_t;

  vec_t vt [6];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, r0, u0, f0, o0;
    logic [15:0] sw, sw2;
    logic [7:0] fifo_exp [5];

    vt[0] = '{k: 0, tx: 16'h00A5, mw: 16'h003C, exp_rx: 16'h003C, exp_miso: 16'h00A5};
    vt[1] = '{k: 1, tx: 16'h007E, mw: 16'h0081, exp_rx: 16'h0081, exp_miso: 16'h007E};
    vt[2] = '{k: 2, tx: 16'h007E, mw: 16'h0081, exp_rx: 16'h0081, exp_miso: 16'h007E};
    vt[3] = '{k: 3, tx: 16'h007E, mw: 16'h0081, exp_rx: 16'h0081, exp_miso: 16'h007E};
    vt[4] = '{k: 0, tx: 16'h005A, mw: 16'h00C3, exp_rx: 16'h00C3, exp_miso: 16'h005A};
    vt[5] = '{k: 4, tx: 16'h1234, mw: 16'hBEEF, exp_rx: 16'hBEEF, exp_miso: 16'h1234};

    for (int i = 0; i < NI; i++) begin
      sclk[i] = cpol_of(i);
      ss[i] = 1'b1;
      txv[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) txd8[i] = 8'h00;
    txd16 = 16'h0000;

    tick(4);
    rst = 1'b0;
    tick(2);

    // Reset state
    check("reset_tx_ready", {31'd0, txr[0]}, 32'd1);
    check("reset_miso_oe", {31'd0, oe[0]}, 32'd0);
    check("reset_busy", {31'd0, busy[0]}, 32'd0);
    check("reset_rx_valid", {31'd0, rxv[0]}, 32'd0);
    check("reset_rx_data", {16'd0, rx_of(0)}, 32'd0);
    check("reset_tx_underrun", {31'd0, und[0]}, 32'd0);
    check("reset_rx_overflow", {31'd0, ovf[0]}, 32'd0);
    check("reset_frame_err", {31'd0, ferr[0]}, 32'd0);

    // Table: one preloaded word per frame in each mode / width
    for (int i = 0; i < 6; i++) begin
      k = vt[i].k;
      r0 = rxv_cnt[k];
      u0 = und_cnt[k];
      f0 = ferr_cnt[k];
      push_tx(k, vt[i].tx);
      ss_low(k);
      check("vec_busy", {31'd0, busy[k]}, 32'd1);
      check("vec_miso_oe", {31'd0, oe[k]}, 32'd1);
      xfer_bits(k, len_of(k), vt[i].mw, sw);
      ss_high(k);
      check("vec_rx_data", {16'd0, last_rx[k]}, {16'd0, vt[i].exp_rx});
      check("vec_rx_valid_count", rxv_cnt[k] - r0, 32'd1);
      check("vec_miso_word", {16'd0, sw}, {16'd0, vt[i].exp_miso});
      check("vec_no_underrun", und_cnt[k] - u0, 32'd0);
      check("vec_no_frame_err", ferr_cnt[k] - f0, 32'd0);
      check("vec_busy_after", {31'd0, busy[k]}, 32'd0);
    end

    // Two back-to-back words with nothing pushed: idle word and two underruns
    r0 = rxv_cnt[0];
    u0 = und_cnt[0];
    ss_low(0);
    xfer_bits(0, 8, 16'h0011, sw);
    xfer_bits(0, 8, 16'h0022, sw2);
    ss_high(0);
    check("underrun_count", und_cnt[0] - u0, 32'd2);
    check("underrun_miso_w1", {16'd0, sw}, 32'h00FF);
    check("underrun_miso_w2", {16'd0, sw2}, 32'h00FF);
    check("underrun_rx_count", rxv_cnt[0] - r0, 32'd2);
    check("underrun_rx_last", {16'd0, last_rx[0]}, 32'h0022);

    // SS raised after 5 bits, then a clean word
    r0 = rxv_cnt[0];
    f0 = ferr_cnt[0];
    ss_low(0);
    xfer_bits(0, 5, 16'h00FF, sw);
    ss_high(0);
    check("frame_err_count", ferr_cnt[0] - f0, 32'd1);
    check("frame_err_no_rx", rxv_cnt[0] - r0, 32'd0);
    push_tx(0, 16'h0096);
    ss_low(0);
    xfer_bits(0, 8, 16'h005B, sw);
    ss_high(0);
    check("after_err_rx_data", {16'd0, last_rx[0]}, 32'h005B);
    check("after_err_rx_count", rxv_cnt[0] - r0, 32'd1);
    check("after_err_miso", {16'd0, sw}, 32'h0096);
    check("after_err_no_new_err", ferr_cnt[0] - f0, 32'd1);

    // Reset in the middle of a 16-bit word
    ss_low(4);
    xfer_bits(4, 7, 16'hFFFF, sw);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("midrst_tx_ready", {31'd0, txr[4]}, 32'd1);
    check("midrst_miso_oe", {31'd0, oe[4]}, 32'd0);
    check("midrst_busy", {31'd0, busy[4]}, 32'd0);
    check("midrst_rx_valid", {31'd0, rxv[4]}, 32'd0);
    check("midrst_rx_data", {16'd0, rx_of(4)}, 32'd0);
    check("midrst_rx_data_k0", {16'd0, rx_of(0)}, 32'd0);
    tick(HC);
    check("midrst_no_restart", {31'd0, busy[4]}, 32'd0);
    ss_high(4);
    r0 = rxv_cnt[4];
    push_tx(4, 16'h1234);
    ss_low(4);
    xfer_bits(4, 16, 16'hBEEF, sw);
    ss_high(4);
    check("postrst_rx_data", {16'd0, last_rx[4]}, 32'h0000BEEF);
    check("postrst_rx_count", rxv_cnt[4] - r0, 32'd1);
    check("postrst_miso", {16'd0, sw}, 32'h00001234);

`ifdef SPI_SLAVE_RX_FIFO_EN
    // FIFO: five words with no consumer, one dropped, first four in order
    fifo_exp[0] = 8'h11; fifo_exp[1] = 8'h22; fifo_exp[2] = 8'h33;
    fifo_exp[3] = 8'h44; fifo_exp[4] = 8'h55;
    rx_rdy = 1'b0;
    o0 = ovf_cnt[0];
    ss_low(0);
    for (int w = 0; w < 5; w++) xfer_bits(0, 8, {8'h00, fifo_exp[w]}, sw);
    ss_high(0);
    check("fifo_overflow_count", ovf_cnt[0] - o0, 32'd1);
    for (int w = 0; w < 4; w++) begin
      check("fifo_rx_valid", {31'd0, rxv[0]}, 32'd1);
      check("fifo_rx_data", {24'd0, rxd8[0]}, {24'd0, fifo_exp[w]});
      rx_rdy = 1'b1;
      tick(1);
      rx_rdy = 1'b0;
    end
    check("fifo_empty_after", {31'd0, rxv[0]}, 32'd0);
    rx_rdy = 1'b1;
`else
    o0 = 0;
    check("no_overflow_ever", ovf_cnt[0] + ovf_cnt[4], o0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
